// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set-2 decoder: pulls bytes from the receive FIFO, merges E0/F0/E1 prefixes,
// tracks modifier state and presents one held key event (code/ext/brk/ascii) to the bus.
module ps2_key_decoder #(
    parameter int PAUSE_SKIP = 7
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    input  logic       kb_ovf,
    output logic       kb_rdn,
    output logic       evt_valid,
    input  logic       evt_ack,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic [7:0] evt_ascii,
    output logic       shift,
    output logic       ctrl,
    output logic       caps,
    output logic       sync_err
);

    localparam int SKIP_W = (PAUSE_SKIP > 1) ? $clog2(PAUSE_SKIP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_kb_rdn;
    logic [7:0]          r_byte;
    logic                r_ext_pend;
    logic                r_brk_pend;
    logic [SKIP_W-1:0]   r_skip_cnt;
    logic                r_evt_valid;
    logic [7:0]          r_evt_code;
    logic                r_evt_ext;
    logic                r_evt_brk;
    logic [7:0]          r_evt_ascii;
    logic                r_shl;
    logic                r_shr;
    logic                r_ctl_l;
    logic                r_ctl_r;
    logic                r_caps;
    logic                r_caps_held;
    logic                r_sync_err;

    logic                w_ext_eff;
    logic                w_brk_eff;
    logic [SKIP_W-1:0]   w_skip_eff;
    logic                w_is_resp;
    logic                w_press;
    logic [7:0]          w_ascii;

    function automatic logic [7:0] f_ascii(input logic [7:0] code, input logic ext,
                                           input logic shf, input logic cap);
        logic [7:0] lc;
        if (ext)
            return (code == 8'h5A) ? 8'h0D : 8'h00;
        case (code)
            8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
            8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
            8'h43: lc = 8'h69;  8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;  8'h4D: lc = 8'h70;
            8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;  8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;
            8'h3C: lc = 8'h75;  8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
            default: lc = 8'h00;
        endcase
        if (lc != 8'h00)
            return (shf ^ cap) ? (lc - 8'h20) : lc;
        case (code)
            8'h16: return shf ? 8'h21 : 8'h31;
            8'h1E: return shf ? 8'h40 : 8'h32;
            8'h26: return shf ? 8'h23 : 8'h33;
            8'h25: return shf ? 8'h24 : 8'h34;
            8'h2E: return shf ? 8'h25 : 8'h35;
            8'h36: return shf ? 8'h5E : 8'h36;
            8'h3D: return shf ? 8'h26 : 8'h37;
            8'h3E: return shf ? 8'h2A : 8'h38;
            8'h46: return shf ? 8'h28 : 8'h39;
            8'h45: return shf ? 8'h29 : 8'h30;
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            8'h76: return 8'h1B;
            8'h0D: return 8'h09;
            default: return 8'h00;
        endcase
    endfunction

    // An ack in the same cycle frees the output register, so the next read can start immediately.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (kb_ready && (!r_evt_valid || evt_ack)) w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= S_IDLE;
            r_kb_rdn <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_kb_rdn <= (w_state_nxt != S_FETCH);
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_FETCH)
            r_byte <= kb_data;
    end

    // Overflow discards any pending prefix/skip state before the current byte is classified.
    always_comb begin
        w_ext_eff  = r_ext_pend & ~kb_ovf;
        w_brk_eff  = r_brk_pend & ~kb_ovf;
        w_skip_eff = kb_ovf ? '0 : r_skip_cnt;
        w_is_resp  = (r_byte == 8'hAA) || (r_byte == 8'hFA) ||
                     (r_byte == 8'hEE) || (r_byte == 8'hFE);
        w_press    = ~w_brk_eff;
        w_ascii    = f_ascii(r_byte, w_ext_eff, r_shl | r_shr, r_caps);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
            r_skip_cnt  <= '0;
            r_evt_valid <= 1'b0;
            r_evt_code  <= 8'h00;
            r_evt_ext   <= 1'b0;
            r_evt_brk   <= 1'b0;
            r_evt_ascii <= 8'h00;
            r_shl       <= 1'b0;
            r_shr       <= 1'b0;
            r_ctl_l     <= 1'b0;
            r_ctl_r     <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            if (r_evt_valid && evt_ack) begin
                r_evt_valid <= 1'b0;
                r_sync_err  <= 1'b0;
            end
            if (r_state == S_DECODE) begin
                if (kb_ovf) begin
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                    r_skip_cnt <= '0;
                    r_sync_err <= 1'b1;
                end
                if (w_skip_eff != '0) begin
                    r_skip_cnt <= w_skip_eff - SKIP_W'(1);
                end else if (r_byte == 8'hE1) begin
                    r_skip_cnt <= SKIP_W'(PAUSE_SKIP);
                end else if (r_byte == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else if ((r_byte == 8'h00) || (r_byte == 8'hFF)) begin
                    r_sync_err <= 1'b1;
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end else if (w_is_resp && !w_ext_eff && !w_brk_eff) begin
                    r_ext_pend <= 1'b0;
                end else begin
                    r_evt_valid <= 1'b1;
                    r_evt_code  <= r_byte;
                    r_evt_ext   <= w_ext_eff;
                    r_evt_brk   <= w_brk_eff;
                    r_evt_ascii <= w_ascii;
                    r_ext_pend  <= 1'b0;
                    r_brk_pend  <= 1'b0;
                    if (!w_ext_eff) begin
                        case (r_byte)
                            8'h12: r_shl   <= w_press;
                            8'h59: r_shr   <= w_press;
                            8'h14: r_ctl_l <= w_press;
                            8'h58: begin
                                if (w_press && !r_caps_held)
                                    r_caps <= ~r_caps;
                                r_caps_held <= w_press;
                            end
                            default: ;
                        endcase
                    end else if (r_byte == 8'h14) begin
                        r_ctl_r <= w_press;
                    end
                end
            end
        end
    end

    assign kb_rdn    = r_kb_rdn;
    assign evt_valid = r_evt_valid;
    assign evt_code  = r_evt_code;
    assign evt_ext   = r_evt_ext;
    assign evt_brk   = r_evt_brk;
    assign evt_ascii = r_evt_ascii;
    assign shift     = r_shl | r_shr;
    assign ctrl      = r_ctl_l | r_ctl_r;
    assign caps      = r_caps;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: FIFO model feeding bytes, hand-checked vectors and sequences,
// then random byte streams compared against a key-state reference model.
module tb_ps2_key_decoder;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } evt_t;

    typedef struct {
        logic [7:0] pre;
        logic [7:0] code;
        logic [7:0] ascii;
    } vec_t;

    localparam logic [7:0] LC_TAB [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DG_TAB [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46, 8'h45};
    localparam logic [7:0] SY_TAB [10] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
        8'h2A, 8'h28, 8'h29};
    localparam logic [7:0] POOL [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h16, 8'h1E,
        8'h45, 8'h29, 8'h5A, 8'h66, 8'h12, 8'h59, 8'h14, 8'h58, 8'hF0, 8'hF0, 8'hF0, 8'hE0,
        8'hE0, 8'hAA, 8'hFA, 8'h75, 8'h0D, 8'h76, 8'h4D};

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_ovf = 1'b0;
    logic       kb_rdn;
    logic       evt_valid;
    logic       evt_ack = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic [7:0] evt_ascii;
    logic       shift;
    logic       ctrl;
    logic       caps;
    logic       sync_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] fifo_q [$];
    logic       rd_s;

    evt_t exp_q [$];
    bit   held [512];
    bit   m_ext, m_brk, m_caps;
    int   m_skip;

    ps2_key_decoder #(.PAUSE_SKIP(7)) dut (
        .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready), .kb_ovf(kb_ovf),
        .kb_rdn(kb_rdn), .evt_valid(evt_valid), .evt_ack(evt_ack), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_ascii(evt_ascii), .shift(shift),
        .ctrl(ctrl), .caps(caps), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO: a low read strobe seen at an edge pops the head just after that edge.
    always @(posedge clk) begin
        rd_s = !kb_rdn;
        #1;
        if (rd_s && fifo_q.size() > 0)
            fifo_q.delete(0);
        kb_ready = (fifo_q.size() != 0);
        kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic evt_t mk(input logic [7:0] c, input logic e, input logic b,
                                input logic [7:0] a);
        evt_t ev;
        ev.code = c; ev.ext = e; ev.brk = b; ev.ascii = a;
        return ev;
    endfunction

    function automatic logic [7:0] model_ascii(input logic [7:0] c, input bit e,
                                               input bit sh, input bit cp);
        if (e) return (c == 8'h5A) ? 8'h0D : 8'h00;
        for (int i = 0; i < 26; i++)
            if (LC_TAB[i] == c) return (sh ^ cp) ? 8'h41 + 8'(i) : 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++)
            if (DG_TAB[i] == c) return sh ? SY_TAB[i] : ((i == 9) ? 8'h30 : 8'h31 + 8'(i));
        case (c)
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            8'h76: return 8'h1B;
            8'h0D: return 8'h09;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit m_shift();
        return held[9'h012] || held[9'h059];
    endfunction

    function automatic bit m_ctrl();
        return held[9'h014] || held[9'h114];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 512; i++) held[i] = 1'b0;
        m_ext = 0; m_brk = 0; m_caps = 0; m_skip = 0;
    endtask

    // Reference: keys held are a set indexed by {ext,code}; events come out in byte order.
    task automatic model_byte(input logic [7:0] b);
        evt_t ev;
        int   k;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'h00 || b == 8'hFF) begin m_ext = 0; m_brk = 0; end
        else if ((b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) && !m_ext && !m_brk) ;
        else begin
            ev = mk(b, m_ext, m_brk, model_ascii(b, m_ext, m_shift(), m_caps));
            exp_q.push_back(ev);
            k = {23'd0, m_ext, b};
            if (!m_brk && k == 9'h058 && !held[k]) m_caps = !m_caps;
            held[k] = !m_brk;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        fifo_q.push_back(b);
        model_byte(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        evt_ack = 1'b0;
        kb_ovf = 1'b0;
        fifo_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int n);
        int g = 0;
        while ((fifo_q.size() != 0 || kb_ready) && g < 500) begin
            @(negedge clk);
            g++;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic get_evt(output evt_t ev, output logic se);
        int n = 0;
        ev = '0;
        se = 1'b0;
        while (!evt_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!evt_valid) begin
            checks++;
            errors++;
            $display("FAIL evt_timeout: got no event after %0d cycles expected one", n);
            return;
        end
        ev = {evt_code, evt_ext, evt_brk, evt_ascii};
        se = sync_err;
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
    endtask

    task automatic expect_evt(input string name, input evt_t exp);
        evt_t ev;
        logic se;
        get_evt(ev, se);
        chk(name, ev, exp);
    endtask

    task automatic expect_quiet(input string name);
        wait_idle(6);
        chk(name, evt_valid, 1'b0);
    endtask

    task automatic drain();
        int   idle = 0;
        int   guard = 0;
        evt_t ev;
        while (guard < 20000) begin
            @(negedge clk);
            guard++;
            if (evt_valid) begin
                idle = 0;
                ev = {evt_code, evt_ext, evt_brk, evt_ascii};
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_evt", ev, 32'hFFFF_FFFF);
                end else begin
                    chk("rand_evt", ev, exp_q[0]);
                    exp_q.delete(0);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                evt_ack = 1'b1;
                @(negedge clk);
                evt_ack = 1'b0;
            end else if (fifo_q.size() == 0 && !kb_ready) begin
                idle++;
                if (idle > 6) break;
            end else begin
                idle = 0;
            end
        end
        chk("rand_leftover_expected", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vec_t vt [14];
        evt_t ev;
        logic se;
        int   rdy, first, lows, g;

        vt[0]  = '{8'h00, 8'h1C, 8'h61};
        vt[1]  = '{8'h00, 8'h1A, 8'h7A};
        vt[2]  = '{8'h00, 8'h4D, 8'h70};
        vt[3]  = '{8'h00, 8'h16, 8'h31};
        vt[4]  = '{8'h00, 8'h45, 8'h30};
        vt[5]  = '{8'h00, 8'h29, 8'h20};
        vt[6]  = '{8'h00, 8'h5A, 8'h0D};
        vt[7]  = '{8'hE0, 8'h5A, 8'h0D};
        vt[8]  = '{8'hE0, 8'h75, 8'h00};
        vt[9]  = '{8'h00, 8'h66, 8'h08};
        vt[10] = '{8'h00, 8'h76, 8'h1B};
        vt[11] = '{8'h00, 8'h0D, 8'h09};
        vt[12] = '{8'h00, 8'h05, 8'h00};
        vt[13] = '{8'hE0, 8'h1C, 8'h00};

        // reset state, sampled while reset is held
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        chk("rst_kb_rdn", kb_rdn, 1'b1);
        chk("rst_evt_valid", evt_valid, 1'b0);
        chk("rst_code_ascii", {evt_code, evt_ascii}, 16'h0000);
        chk("rst_flags", {evt_ext, evt_brk, shift, ctrl, caps, sync_err}, 6'b0);
        do_reset();

        // latency and single read strobe for one byte
        send(8'h1C);
        g = 0;
        while (!kb_ready && g < 20) begin @(negedge clk); g++; end
        rdy = cyc; first = -1; lows = 0;
        for (int i = 0; i < 12; i++) begin
            if (!kb_rdn) lows++;
            if (evt_valid && first < 0) first = cyc;
            @(negedge clk);
        end
        chk("lat_edges", first - rdy, 3);
        chk("lat_rdn_pulses", lows, 1);
        expect_evt("lat_evt", mk(8'h1C, 1'b0, 1'b0, 8'h61));

        for (int i = 0; i < 14; i++) begin
            if (vt[i].pre != 8'h00) send(vt[i].pre);
            send(vt[i].code);
            get_evt(ev, se);
            chk($sformatf("vec%0d", i), ev, mk(vt[i].code, vt[i].pre == 8'hE0, 1'b0, vt[i].ascii));
        end

        // shifted letters and release events
        do_reset();
        send(8'h12);
        expect_evt("sh_press12", mk(8'h12, 1'b0, 1'b0, 8'h00));
        chk("sh_held", shift, 1'b1);
        send(8'h1C);
        expect_evt("sh_A", mk(8'h1C, 1'b0, 1'b0, 8'h41));
        send(8'hF0); send(8'h1C);
        expect_evt("sh_A_rel", mk(8'h1C, 1'b0, 1'b1, 8'h41));
        chk("sh_still", shift, 1'b1);
        send(8'hF0); send(8'h12);
        expect_evt("sh_rel12", mk(8'h12, 1'b0, 1'b1, 8'h00));
        chk("sh_clear", shift, 1'b0);
        send(8'h59); send(8'h16);
        expect_evt("shr_press", mk(8'h59, 1'b0, 1'b0, 8'h00));
        expect_evt("shr_bang", mk(8'h16, 1'b0, 1'b0, 8'h21));
        send(8'hF0); send(8'h59);
        expect_evt("shr_rel", mk(8'h59, 1'b0, 1'b1, 8'h00));

        send(8'hE0); send(8'hF0); send(8'h75);
        expect_evt("ext_brk", mk(8'h75, 1'b1, 1'b1, 8'h00));
        expect_quiet("ext_brk_single");
        send(8'hE0); send(8'h14);
        expect_evt("rctl_press", mk(8'h14, 1'b1, 1'b0, 8'h00));
        chk("rctl_held", ctrl, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h14);
        expect_evt("rctl_rel", mk(8'h14, 1'b1, 1'b1, 8'h00));
        chk("rctl_clear", ctrl, 1'b0);

        // caps toggles only on a fresh press
        send(8'h58);
        expect_evt("caps_p1", mk(8'h58, 1'b0, 1'b0, 8'h00));
        chk("caps_on", caps, 1'b1);
        send(8'h58);
        expect_evt("caps_rep", mk(8'h58, 1'b0, 1'b0, 8'h00));
        chk("caps_rep_keep", caps, 1'b1);
        send(8'hF0); send(8'h58);
        expect_evt("caps_rel", mk(8'h58, 1'b0, 1'b1, 8'h00));
        send(8'h1C);
        expect_evt("caps_A", mk(8'h1C, 1'b0, 1'b0, 8'h41));
        send(8'h58);
        expect_evt("caps_p2", mk(8'h58, 1'b0, 1'b0, 8'h00));
        chk("caps_off", caps, 1'b0);

        // pause sequence swallowed
        do_reset();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h29);
        expect_evt("pause_then29", mk(8'h29, 1'b0, 1'b0, 8'h20));
        expect_quiet("pause_single");
        chk("pause_mods", {shift, ctrl}, 2'b00);

        send(8'hAA); send(8'hFE); send(8'h1C);
        expect_evt("resp_discard", mk(8'h1C, 1'b0, 1'b0, 8'h61));
        send(8'hF0); send(8'hAA);
        expect_evt("resp_prefixed", mk(8'hAA, 1'b0, 1'b1, 8'h00));

        // back-pressure: no reads while an event is held
        send(8'h1C); send(8'h32); send(8'h21);
        g = 0;
        while (!evt_valid && g < 50) begin @(negedge clk); g++; end
        ev = {evt_code, evt_ext, evt_brk, evt_ascii};
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!kb_rdn) lows++;
        end
        chk("bp_no_read", lows, 0);
        chk("bp_first", ev, mk(8'h1C, 1'b0, 1'b0, 8'h61));
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
        chk("bp_read_after_ack", {kb_rdn, evt_valid}, 2'b00);
        expect_evt("bp_second", mk(8'h32, 1'b0, 1'b0, 8'h62));
        expect_evt("bp_third", mk(8'h21, 1'b0, 1'b0, 8'h63));

        // reset in the middle of a prefixed code
        send(8'hE0);
        wait_idle(4);
        do_reset();
        send(8'h1C);
        expect_evt("rst_mid_noext", mk(8'h1C, 1'b0, 1'b0, 8'h61));

        // overflow clears the pending prefix and raises sync_err until ack
        send(8'hE0);
        wait_idle(4);
        kb_ovf = 1'b1;
        send(8'h1C);
        get_evt(ev, se);
        chk("ovf_evt", ev, mk(8'h1C, 1'b0, 1'b0, 8'h61));
        chk("ovf_sync_set", se, 1'b1);
        chk("ovf_sync_acked", sync_err, 1'b0);
        kb_ovf = 1'b0;

        send(8'h00);
        wait_idle(4);
        chk("zero_sync_set", {sync_err, evt_valid}, 2'b10);
        send(8'h1C);
        get_evt(ev, se);
        chk("zero_then_evt", ev, mk(8'h1C, 1'b0, 1'b0, 8'h61));
        chk("zero_sync_held", se, 1'b1);
        chk("zero_sync_acked", sync_err, 1'b0);

        // random streams against the reference model
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 39) == 0) send(8'hE1);
                else if ($urandom_range(0, 59) == 0) send(8'h00);
                else send(POOL[$urandom_range(0, 25)]);
            end
            drain();
            chk("rand_shift", shift, m_shift());
            chk("rand_ctrl", ctrl, m_ctrl());
            chk("rand_caps", caps, m_caps);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
